// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5..9 data bits, none/even/odd
// parity, 1 or 2 stop bits) with 3-tap majority sampling, false-start
// rejection, parity/framing/break status and a valid/ready output register.
module uart_rx_cfg #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CPB   = CLK_FREQ / BAUD;
  localparam int unsigned HALF  = CPB / 2;
  localparam int unsigned CNT_W = $clog2(CPB);
  localparam int unsigned BIT_W = 4;

  localparam logic [CNT_W-1:0] C_S0  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] C_S1  = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] C_DEC = CNT_W'(HALF + 1);
  localparam logic [CNT_W-1:0] C_END = CNT_W'(CPB - 1);

  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_s0;
  logic                 r_s1;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_stop0;
  logic                 r_ferr_pend;

  logic w_vote;
  logic w_dec;
  logic w_end;
  logic w_last_stop;
  logic w_complete;
  logic w_ferr;
  logic w_stop0;
  logic w_perr;
  logic w_brk;
  logic w_accept;

  // Two-flop synchroniser for the asynchronous line; deliberately not reset.
  always_ff @(posedge clk) begin
    r_rx_meta <= rx;
    r_rx_s    <= r_rx_meta;
  end

  assign w_vote      = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
  assign w_dec       = (r_cnt == C_DEC);
  assign w_end       = (r_cnt == C_END);
  assign w_last_stop = (r_bit == LAST_STOP);
  assign w_complete  = (r_state == S_STOP) && w_dec && w_last_stop;
  assign w_ferr      = r_ferr_pend | ~w_vote;
  // With one stop bit the first stop vote is the one being decided right now.
  assign w_stop0     = (r_bit == '0) ? w_vote : r_stop0;
  assign w_brk       = (r_shift == '0) && !r_par && !w_stop0;
  assign w_accept    = data_valid && data_ready;
  assign busy        = (r_state != S_IDLE);

  // Parity check over the assembled word plus the received parity bit.
  always_comb begin
    w_perr = 1'b0;
    if (PARITY != 0) begin
      w_perr = ((^r_shift) ^ r_par) != (PARITY == 2);
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode driven by the bit timer and majority vote.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) w_next = S_START;
      end
      S_START: begin
        if (w_dec && w_vote) w_next = S_IDLE;
        else if (w_end)      w_next = S_DATA;
      end
      S_DATA: begin
        if (w_end && (r_bit == LAST_DATA)) begin
          w_next = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_end) w_next = S_STOP;
      end
      S_STOP: begin
        if (w_complete) w_next = w_ferr ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (r_rx_s) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Bit timer, vote samples, bit index and per-frame pending status.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_s0        <= 1'b0;
      r_s1        <= 1'b0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_stop0     <= 1'b0;
      r_ferr_pend <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) || (r_state == S_WAIT) || w_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_cnt == C_S0) r_s0 <= r_rx_s;
      if (r_cnt == C_S1) r_s1 <= r_rx_s;

      case (r_state)
        S_START: begin
          r_bit       <= '0;
          r_par       <= 1'b0;
          r_ferr_pend <= 1'b0;
        end
        S_DATA: begin
          if (w_dec) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
          if (w_end) r_bit <= (r_bit == LAST_DATA) ? '0 : r_bit + 1'b1;
        end
        S_PARITY: begin
          if (w_dec) r_par <= w_vote;
        end
        S_STOP: begin
          if (w_dec && (r_bit == '0)) r_stop0 <= w_vote;
          if (w_dec && !w_vote)       r_ferr_pend <= 1'b1;
          if (w_end)                  r_bit <= r_bit + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output register: load when empty or being drained, otherwise flag overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      data       <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (w_complete && (!data_valid || w_accept)) begin
        data       <= r_shift;
        data_valid <= 1'b1;
        parity_err <= w_perr;
        frame_err  <= w_ferr;
        break_det  <= w_brk;
      end else if (w_complete) begin
        overrun <= 1'b1;
      end else if (w_accept) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: four instances (8N1, 7E1, 8N2, 9O1) at CPB = 10,
// directed steps plus randomized frames checked against a frame-level model.
module tb_uart_rx_cfg;

  localparam int CF  = 1000000;
  localparam int BD  = 100000;
  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rx_v;
  logic [3:0] rdy_v;
  logic [3:0] vld, pe, fe, bk, ov, bsy;
  logic [7:0] d0;
  logic [6:0] d1;
  logic [7:0] d2;
  logic [8:0] d3;
  logic [8:0] dat [4];

  assign dat[0] = {1'b0, d0};
  assign dat[1] = {2'b0, d1};
  assign dat[2] = {1'b0, d2};
  assign dat[3] = d3;

  uart_rx_cfg #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .rx(rx_v[0]), .data(d0), .data_valid(vld[0]), .data_ready(rdy_v[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .break_det(bk[0]), .overrun(ov[0]), .busy(bsy[0]));
  uart_rx_cfg #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_7e1 (
    .clk(clk), .rst(rst), .rx(rx_v[1]), .data(d1), .data_valid(vld[1]), .data_ready(rdy_v[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .break_det(bk[1]), .overrun(ov[1]), .busy(bsy[1]));
  uart_rx_cfg #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .rx(rx_v[2]), .data(d2), .data_valid(vld[2]), .data_ready(rdy_v[2]),
    .parity_err(pe[2]), .frame_err(fe[2]), .break_det(bk[2]), .overrun(ov[2]), .busy(bsy[2]));
  uart_rx_cfg #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(9), .PARITY(2), .STOP_BITS(1)) u_9o1 (
    .clk(clk), .rst(rst), .rx(rx_v[3]), .data(d3), .data_valid(vld[3]), .data_ready(rdy_v[3]),
    .parity_err(pe[3]), .frame_err(fe[3]), .break_det(bk[3]), .overrun(ov[3]), .busy(bsy[3]));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] inst;
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       bk;
  } word_t;

  word_t      capq[$];
  int         cyc = 0;
  int         rises[4];
  int         hicnt[4];
  int         ovcnt[4];
  int         rise_cyc[4];
  logic [3:0] prev_v = '0;
  int         n_tests = 0;
  int         n_fail = 0;

  always @(posedge clk) cyc++;

  // Collects accepted words and counts valid rises/high cycles and overrun pulses.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (vld[i] === 1'b1) hicnt[i]++;
      if ((vld[i] === 1'b1) && (prev_v[i] !== 1'b1)) begin
        rises[i]++;
        rise_cyc[i] = cyc;
      end
      if (ov[i] === 1'b1) ovcnt[i]++;
      if ((vld[i] === 1'b1) && (rdy_v[i] === 1'b1)) begin
        capq.push_back('{inst: 4'(i), data: dat[i], pe: pe[i], fe: fe[i], bk: bk[i]});
      end
    end
    prev_v = vld;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int inst, input logic v, input int n);
    rx_v[inst] = v;
    tick(n);
  endtask

  // Serialises one frame; gl selects a data bit that receives a one-clock
  // inverted glitch on its centre sample (-1 for none). Returns the status
  // the receiver must report for this frame.
  task automatic send_frame(input int inst, input logic [8:0] d, input int nb, input int pm,
                            input bit flip, input logic [1:0] slo, input int ns, input int gl,
                            output logic epe, output logic efe, output logic ebk);
    int   ones;
    logic pb;
    ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(d[i]);
    pb = ((ones % 2) == 1);
    if (pm == 2) pb = !pb;
    pb = pb ^ flip;
    drv(inst, 1'b0, CPB);
    for (int i = 0; i < nb; i++) begin
      if (i == gl) begin
        drv(inst, d[i], 6);
        drv(inst, !d[i], 1);
        drv(inst, d[i], 3);
      end else begin
        drv(inst, d[i], CPB);
      end
    end
    if (pm != 0) drv(inst, pb, CPB);
    for (int s = 0; s < ns; s++) drv(inst, !slo[s], CPB);
    drv(inst, 1'b1, 2 * CPB);
    epe = (pm != 0) && flip;
    efe = slo[0] || ((ns == 2) && slo[1]);
    ebk = (d == '0) && ((pm == 0) || !pb) && slo[0];
  endtask

  task automatic pop_check(input string tag, input int inst, input logic [8:0] ed,
                           input logic epe, input logic efe, input logic ebk);
    word_t w;
    check({tag, "_avail"}, capq.size(), 1);
    if (capq.size() > 0) begin
      w = capq.pop_front();
      check({tag, "_inst"}, w.inst, inst);
      check({tag, "_data"}, w.data, ed);
      check({tag, "_perr"}, w.pe, epe);
      check({tag, "_ferr"}, w.fe, efe);
      check({tag, "_brk"},  w.bk, ebk);
    end
  endtask

  initial begin
    logic       epe, efe, ebk;
    logic [8:0] rd;
    int         c0, r0, h0, o0, inst, nb, pm;
    bit         flip;
    logic [1:0] slo;

    rx_v  = '1;
    rdy_v = '1;
    rst   = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Reset state
    check("rst_valid", vld, 4'h0);
    check("rst_busy", bsy, 4'h0);
    check("rst_ovr", ov, 4'h0);
    check("rst_flags", {pe, fe, bk}, 12'h000);
    for (int i = 0; i < 4; i++) check("rst_data", dat[i], 9'h000);

    // 1: 8N1 0xA5, one valid cycle, rise one cycle after the stop decision
    r0 = rises[0];
    h0 = hicnt[0];
    c0 = cyc;
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 2'b00, 1, -1, epe, efe, ebk);
    check("t1_rises", rises[0] - r0, 1);
    check("t1_hicyc", hicnt[0] - h0, 1);
    // sync (2) + idle detect (1) + 9 full bits before the stop bit + centre decision (HALF+1) + 1
    check("t1_latency", rise_cyc[0] - c0, 3 + 9 * CPB + (CPB / 2 + 1) + 1);
    pop_check("t1", 0, 9'h0A5, epe, efe, ebk);

    // 2: 7E1 0x41 with correct, then corrupted, parity bit
    send_frame(1, 9'h041, 7, 1, 1'b0, 2'b00, 1, -1, epe, efe, ebk);
    pop_check("t2_ok", 1, 9'h041, epe, efe, ebk);
    check("t2_ok_model", epe, 1'b0);
    send_frame(1, 9'h041, 7, 1, 1'b1, 2'b00, 1, -1, epe, efe, ebk);
    pop_check("t2_bad", 1, 9'h041, epe, efe, ebk);

    // 3: 3-clock low pulse is rejected; data-bit glitch is outvoted
    r0 = rises[0];
    drv(0, 1'b0, 3);
    drv(0, 1'b1, 2);
    check("t3_busy_start", bsy[0], 1'b1);
    drv(0, 1'b1, 10);
    check("t3_busy_idle", bsy[0], 1'b0);
    tick(20);
    check("t3_no_word", rises[0] - r0, 0);
    send_frame(0, 9'h05A, 8, 0, 1'b0, 2'b00, 1, 3, epe, efe, ebk);
    pop_check("t3_glitch", 0, 9'h05A, epe, efe, ebk);

    // 4: break for 20 bit times
    r0 = rises[0];
    drv(0, 1'b0, 150);
    check("t4_wait_busy", bsy[0], 1'b1);
    drv(0, 1'b0, 50);
    drv(0, 1'b1, 30);
    check("t4_idle", bsy[0], 1'b0);
    check("t4_one_word", rises[0] - r0, 1);
    pop_check("t4_brk", 0, 9'h000, 1'b0, 1'b1, 1'b1);
    send_frame(0, 9'h03C, 8, 0, 1'b0, 2'b00, 1, -1, epe, efe, ebk);
    pop_check("t4_after", 0, 9'h03C, epe, efe, ebk);

    // 5: back-pressure and overrun
    rdy_v[0] = 1'b0;
    r0 = rises[0];
    o0 = ovcnt[0];
    send_frame(0, 9'h011, 8, 0, 1'b0, 2'b00, 1, -1, epe, efe, ebk);
    send_frame(0, 9'h022, 8, 0, 1'b0, 2'b00, 1, -1, epe, efe, ebk);
    check("t5_held_valid", vld[0], 1'b1);
    check("t5_held_data", dat[0], 9'h011);
    check("t5_ovr_pulses", ovcnt[0] - o0, 1);
    check("t5_rises", rises[0] - r0, 1);
    rdy_v[0] = 1'b1;
    tick(1);
    check("t5_drained", vld[0], 1'b0);
    pop_check("t5", 0, 9'h011, 1'b0, 1'b0, 1'b0);
    tick(40);
    check("t5_lost", rises[0] - r0, 1);
    check("t5_q_empty", capq.size(), 0);

    // Randomized frames on 8N1, 7E1 and 9O1 against the frame model
    for (int k = 0; k < 15; k++) begin
      inst = (k % 3 == 0) ? 0 : ((k % 3 == 1) ? 1 : 3);
      nb   = (inst == 0) ? 8 : ((inst == 1) ? 7 : 9);
      pm   = (inst == 0) ? 0 : ((inst == 1) ? 1 : 2);
      rd   = 9'($urandom_range(0, (1 << nb) - 1));
      if ($urandom_range(0, 5) == 0) rd = '0;
      flip = ($urandom_range(0, 3) == 0);
      slo  = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00;
      send_frame(inst, rd, nb, pm, flip, slo, 1, -1, epe, efe, ebk);
      pop_check("rand", inst, rd, epe, efe, ebk);
    end

    // 6: 8N2 with second stop bit low, then reset mid-frame
    rdy_v[2] = 1'b0;
    send_frame(2, 9'h03C, 8, 0, 1'b0, 2'b10, 2, -1, epe, efe, ebk);
    check("t6_valid", vld[2], 1'b1);
    check("t6_data", dat[2], 9'h03C);
    check("t6_ferr", fe[2], efe);
    check("t6_brk", bk[2], ebk);
    check("t6_perr", pe[2], epe);
    r0 = rises[2];
    drv(2, 1'b0, CPB);
    drv(2, 1'b1, 15);
    check("t6_busy_mid", bsy[2], 1'b1);
    rst = 1'b1;
    tick(1);
    check("t6_rst_valid", vld[2], 1'b0);
    check("t6_rst_data", dat[2], 9'h000);
    check("t6_rst_flags", {pe[2], fe[2], bk[2], ov[2]}, 4'h0);
    check("t6_rst_busy", bsy[2], 1'b0);
    rst = 1'b0;
    drv(2, 1'b1, 60);
    check("t6_no_word", rises[2] - r0, 0);
    check("t6_q_empty", capq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver and successor to the fixed 8N1/9600 receiver. It takes a raw asynchronous rx line and delivers complete frames as words on a valid/ready output. Frame format is configurable: data width, parity mode and stop bit count. Each bit is sampled by a 3-tap majority vote, false start bits are rejected, and each delivered word carries parity, framing, break and overrun status. It sits between the board rx pin and downstream command or FIFO logic.

Parameters:
CLK_FREQ, 50000000, system clock in Hz
BAUD, 9600, line rate in bit/s. CPB = CLK_FREQ/BAUD (integer division); CPB must be >= 8
DATA_BITS, 8, data bits per frame, legal range 5..9, sent LSB first
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame, 1 or 2

Ports:
clk  in  1  system clock; the only clock
rst  in  1  synchronous, active-high reset
rx  in  1  asynchronous serial input; idles high
data  out  DATA_BITS  received word; stable while data_valid = 1
data_valid  out  1  word available; held high until accepted
data_ready  in  1  consumer accepts the word when data_valid && data_ready on a rising clk edge
parity_err  out  1  sideband for the held word; always 0 when PARITY = 0
frame_err  out  1  sideband for the held word: a stop bit was sampled low
break_det  out  1  sideband for the held word: all data bits 0, parity bit (if any) 0, and first stop bit 0
overrun  out  1  one-cycle pulse when a completed frame is dropped
busy  out  1  high in every state except S_IDLE

Behaviour:
- Input path: rx passes through a 2-flop synchroniser to give rx_s. All logic uses rx_s only. The synchroniser flops are not reset.
- Reset: state = S_IDLE, counters = 0. data_valid, parity_err, frame_err, break_det, overrun and busy are all 0. data is 0. Reset mid-frame abandons the frame with no output.
- Bit timer: counts 0..CPB-1 inside each bit period and clears on every bit boundary.
- Majority vote: rx_s is sampled at counts HALF-1, HALF and HALF+1, where HALF = CPB/2. The bit value is the majority of the three samples, decided at count HALF+1.
- State machine:
  - S_IDLE: on rx_s = 0, go to S_START and clear the timer.
  - S_START: at the majority decision point, go to S_IDLE if the start bit votes 1 (glitch rejected, no output). Otherwise continue the period and go to S_DATA at count CPB-1.
  - S_DATA: shift the voted bit into bit index 0..DATA_BITS-1. After the last bit, go to S_PARITY if PARITY != 0, otherwise go to S_STOP.
  - S_PARITY: compute even parity as the XOR of the data bits and the parity bit; the result must be 0. For odd parity the result must be 1. Any mismatch sets the pending parity_err.
  - S_STOP: vote each of the STOP_BITS stop bits; any stop bit voted 0 sets the pending frame_err. The frame completes at the decision point of the last stop bit, not at the end of that bit period.
    - If frame_err = 0, go to S_IDLE at completion.
    - If frame_err = 1, go to S_WAIT at completion.
  - S_WAIT: hold until rx_s = 1, then go to S_IDLE. This prevents a break from retriggering repeated starts.
- Completion: on the cycle after the frame completes, the word and its sideband flags are loaded into the output register and data_valid goes to 1.
- Handshake:
  - data_valid clears on the cycle after data_valid && data_ready.
  - The output register is loaded only when it is empty or is being accepted in the same cycle. Completion and acceptance in the same cycle gives load, with data_valid staying 1.
  - Completion while data_valid = 1 and data_ready = 0: the new frame is dropped, the held word and its flags are unchanged, and overrun pulses high for 1 cycle.
- Flags are not sticky. They describe only the currently held word and are valid whenever data_valid = 1.
- The receiver keeps receiving regardless of data_ready. Back-pressure never stalls line sampling.

Test Plan:
The bench uses CLK_FREQ = 1000000 and BAUD = 100000, so CPB = 10.
1. Default 8N1 format, send 0xA5 with data_ready = 1 → one data_valid cycle with data = 0xA5 and all flags 0. data_valid rises 1 cycle after the stop-bit decision point.
2. DATA_BITS = 7, PARITY = 1, send 0x41 with parity bit 0 → data = 0x41, parity_err = 0. Resend with parity bit 1 → data = 0x41, parity_err = 1.
3. Low pulse of 3 clocks on rx while idle → state returns to S_IDLE, no data_valid. Single-clock glitch of 1 in the middle of data bit 3 → the majority vote rejects it and the word is correct.
4. Hold rx low for 20 bit times, then release → one word with data = 0, frame_err = 1, break_det = 1. No further words until rx has been high and a new start bit is sent.
5. data_ready = 0, send 0x11 then 0x22 → data_valid is held with data = 0x11 and overrun pulses once at the second completion. Raise data_ready → 0x11 is accepted and data_valid drops; 0x22 is lost.
6. STOP_BITS = 2, send 0x3C with the second stop bit low → data = 0x3C, frame_err = 1. Assert rst mid-frame → all outputs 0 next cycle, no word emitted.
